chacha20_byte_packer: RTL and testbench
=======================================

// Module: chacha20_byte_packer
// PURPOSE
//  Upstream stage of the ChaCha20 encrypt datapath: accepts a byte stream (valid/ready/last) and packs it into
//  32*DATA_WIDTH_WORDS-bit words for the encryptor's plaintext port. Zero-pads the final partial word,
//  reports its valid bytes on out_keep and reports total message length. One accumulator plus one output register.
// PARAMETERS
//  DATA_WIDTH_WORDS  1                      words per output beat; must match the encryptor
//  ENDIANNESS        `CHACHA20_ENDIANNESS   0: first byte of a word in [7:0] (LE); 1: first byte in [31:24]
// PORTS
//  clk        in   1                    clock
//  rst_n      in   1                    asynchronous active-low reset
//  in_byte    in   8                    input byte
//  in_valid   in   1                    in_byte valid
//  in_last    in   1                    final byte of message (qualified by in_valid)
//  in_ready   out  1                    packer can accept in_byte
//  out_data   out  32*DATA_WIDTH_WORDS  packed word(s); word i at [32i+:32]
//  out_keep   out  4*DATA_WIDTH_WORDS   byte-valid mask; bit 4i+k = byte k of word i
//  out_valid  out  1                    out_data valid (drives encryptor plaintext_valid)
//  out_last   out  1                    beat carries final byte (drives plaintext_last)
//  out_ready  in   1                    downstream accepts (from encryptor plaintext_ready)
//  msg_len    out  32                   byte count of last completed message
//  msg_done   out  1                    1-cycle pulse when the out_last beat is accepted
// BEHAVIOUR
//  - Reset (async): out_data=0, out_keep=0, out_valid=0, out_last=0, msg_len=0, msg_done=0, accumulator empty,
//    byte index=0, running count=0. in_ready=1 after reset. Reset mid-message discards all partial data.
//  - Handshakes: in: byte transfers when in_valid&&in_ready. out: beat transfers when out_valid&&out_ready.
//    out_data/keep/last stable while out_valid&&!out_ready.
//  - Accumulator states: FILLING (index 0..4W-1), FULL (word complete, waiting for the output register).
//    in_ready = (state==FILLING); purely registered, no combinational path from out_ready.
//  - Byte n of a beat (n=0..4W-1) goes to word n/4, lane n%4; lane position set by ENDIANNESS.
//  - A word completes on the byte that makes index==4W-1 or carries in_last. Same edge:
//    if output slot is free (!out_valid || out_ready), load out_* directly; out_valid=1 next cycle.
//    Accumulator clears, index=0, stays FILLING. Otherwise go FULL. The load happens on the first edge
//    where the slot frees; then return to FILLING.
//  - Latency: completing byte handshake -> out_valid at the next cycle. Throughput: 1 byte/cycle sustained
//    when out_ready is held high.
//  - Padding: unused bytes of a partial final beat = 8'h00. keep bits set for filled bytes only, contiguous from
//    bit 0. Full beats have keep all-ones.
//  - Running count +1 per accepted byte (32-bit, wraps mod 2^32). On acceptance of the in_last byte,
//    msg_len <= count+1 and count <= 0. msg_done pulses on the out_last output handshake, not on input.
//  - Zero-length messages are unsupported: in_last always accompanies a real byte.
//  - in_last with index 4W-1 gives a full-keep beat with out_last=1. No extra empty beat.
// STRUCTURE
//  - Shared header chacha20_defs.vh: `CHACHA20_ENDIANNESS and byte/word width constants (BYTES_PER_WORD=4).
//  - Single module, no sub-modules. Output register plus accumulator form a 2-deep elastic buffer.
// TESTING
//  1. LE, W=1: bytes 01,02,03,04 (last on 04), out_ready=1 -> out_data=32'h04030201, keep=4'hF,
//     out_last=1, msg_len=4, msg_done pulses once.
//  2. BE (ENDIANNESS=1): same stimulus -> out_data=32'h01020304, keep=4'hF.
//  3. 6 bytes AA..AF, last on AF, LE, W=1 -> beats 32'hADACABAA keep F, then 32'h0000AFAE keep 4'h3
//     out_last=1; msg_len=6.
//  4. Backpressure: out_ready=0 while 8 bytes are offered -> first beat held stable, in_ready drops after
//     byte 8 (FULL). Raise out_ready -> both beats delivered in order, none lost or duplicated.
//  5. W=2, 9 bytes 00..08 -> beat0 = {32'h07060504,32'h03020100} keep FF, beat1 keep 8'h01 data 64'h08.
//  6. Assert rst_n low after 3 bytes of a message -> outputs at reset values the same cycle. A new 4-byte message
//     then packs from lane 0 with msg_len=4.

Source files
------------

// File: rtl/chacha20_byte_packer_pkg.sv
// chacha20_byte_packer_pkg: shared widths, default lane order, accumulator state and lane-position helper
package chacha20_byte_packer_pkg;
   localparam int BYTE_W = 8;
   localparam int BYTES_PER_WORD = 4;
   localparam int WORD_W = BYTE_W * BYTES_PER_WORD;
   // 0: first byte of a word in [7:0]; 1: first byte in [31:24]
   localparam bit CHACHA20_ENDIANNESS = 1'b0;
   typedef enum logic {FILLING, FULL} acc_state_t;
   // bit offset of beat byte idx: word idx/4 at 32*word, lane idx%4 mirrored for big-endian
   function automatic logic [15:0] byte_pos(input logic [15:0] idx, input bit be);
      logic [1:0] lane;
      lane = be ? ~idx[1:0] : idx[1:0];
      return {idx[12:2], 5'b0} + {11'b0, lane, 3'b0};
   endfunction
endpackage

// File: rtl/chacha20_byte_packer.sv
// chacha20_byte_packer: packs a valid/ready byte stream into 32*W-bit beats for the ChaCha20 encryptor
//   clk, rst_n            clock, asynchronous active-low reset
//   in_byte/valid/last    input byte stream; in_ready high while the accumulator is filling
//   out_data/keep/last    packed beat, byte-valid mask, final-beat flag; out_valid/out_ready handshake
//   msg_len, msg_done     length of last completed message; pulse when its final beat is accepted
module chacha20_byte_packer
   import chacha20_byte_packer_pkg::*;
#(
   parameter int DATA_WIDTH_WORDS = 1,
   parameter bit ENDIANNESS = CHACHA20_ENDIANNESS
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [BYTE_W-1:0]                in_byte,
   input  logic                             in_valid,
   input  logic                             in_last,
   output logic                             in_ready,
   output logic [WORD_W*DATA_WIDTH_WORDS-1:0] out_data,
   output logic [4*DATA_WIDTH_WORDS-1:0]    out_keep,
   output logic                             out_valid,
   output logic                             out_last,
   input  logic                             out_ready,
   output logic [31:0]                      msg_len,
   output logic                             msg_done
);
   localparam int NB = BYTES_PER_WORD * DATA_WIDTH_WORDS;
   localparam int DW = WORD_W * DATA_WIDTH_WORDS;
   localparam int IW = $clog2(NB);
   acc_state_t state;
   logic [DW-1:0] acc_data, nxt_data;
   logic [NB-1:0] acc_keep, nxt_keep;
   logic acc_last;
   logic [IW-1:0] idx;
   logic [31:0] count;
   logic take, slot_free, complete;
   // in_ready depends only on the registered state, so out_ready never reaches it combinationally
   assign in_ready = (state == FILLING);
   assign take = in_valid && in_ready;
   assign slot_free = !out_valid || out_ready;
   assign complete = take && (in_last || idx == IW'(NB - 1));
   assign nxt_data = acc_data | (DW'(in_byte) << byte_pos(16'(idx), ENDIANNESS));
   assign nxt_keep = acc_keep | (NB'(1) << idx);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FILLING;
         acc_data <= '0;
         acc_keep <= '0;
         acc_last <= 1'b0;
         idx <= '0;
         count <= '0;
         out_data <= '0;
         out_keep <= '0;
         out_valid <= 1'b0;
         out_last <= 1'b0;
         msg_len <= '0;
         msg_done <= 1'b0;
      end else begin
         msg_done <= out_valid && out_ready && out_last;
         if (out_valid && out_ready)
            out_valid <= 1'b0;
         if (take) begin
            count <= in_last ? 32'd0 : count + 32'd1;
            if (in_last)
               msg_len <= count + 32'd1;
         end
         if (state == FULL && slot_free) begin
            out_data <= acc_data;
            out_keep <= acc_keep;
            out_last <= acc_last;
            out_valid <= 1'b1;
            acc_data <= '0;
            acc_keep <= '0;
            idx <= '0;
            state <= FILLING;
         end else if (complete && slot_free) begin
            // bypass the accumulator: completed word goes straight to the output register
            out_data <= nxt_data;
            out_keep <= nxt_keep;
            out_last <= in_last;
            out_valid <= 1'b1;
            acc_data <= '0;
            acc_keep <= '0;
            idx <= '0;
         end else if (complete) begin
            acc_data <= nxt_data;
            acc_keep <= nxt_keep;
            acc_last <= in_last;
            state <= FULL;
         end else if (take) begin
            acc_data <= nxt_data;
            acc_keep <= nxt_keep;
            idx <= idx + IW'(1);
         end
      end
   end
endmodule

// File: tb/tb_chacha20_byte_packer.sv
// tb_chacha20_byte_packer: randomized and directed checks of three packer configurations against a byte-list model
module tb_chacha20_byte_packer;
   typedef logic [72:0] beat_t;
   typedef beat_t beat_q_t[$];
   typedef logic [7:0] bq_t[$];
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [7:0] in_byte = '0;
   logic in_valid = 1'b0;
   logic in_last = 1'b0;
   logic out_ready = 1'b0;
   int cmp_n = 0;
   int err_n = 0;
   logic [31:0] d0, d1;
   logic [63:0] d2;
   logic [3:0] k0, k1;
   logic [7:0] k2;
   logic [2:0] ov, ol, md, ir;
   logic [31:0] ml[3];
   beat_t obeat[3];
   beat_t cap[3][$];
   beat_t exp_q[3][$];
   int dn[3];
   always #5 clk = ~clk;
   assign obeat[0] = {ol[0], 4'b0, k0, 32'b0, d0};
   assign obeat[1] = {ol[1], 4'b0, k1, 32'b0, d1};
   assign obeat[2] = {ol[2], k2, d2};
   chacha20_byte_packer #(.DATA_WIDTH_WORDS(1), .ENDIANNESS(1'b0)) u_le (
      .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last), .in_ready(ir[0]),
      .out_data(d0), .out_keep(k0), .out_valid(ov[0]), .out_last(ol[0]), .out_ready(out_ready),
      .msg_len(ml[0]), .msg_done(md[0]));
   chacha20_byte_packer #(.DATA_WIDTH_WORDS(1), .ENDIANNESS(1'b1)) u_be (
      .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last), .in_ready(ir[1]),
      .out_data(d1), .out_keep(k1), .out_valid(ov[1]), .out_last(ol[1]), .out_ready(out_ready),
      .msg_len(ml[1]), .msg_done(md[1]));
   chacha20_byte_packer #(.DATA_WIDTH_WORDS(2), .ENDIANNESS(1'b0)) u_w2 (
      .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last), .in_ready(ir[2]),
      .out_data(d2), .out_keep(k2), .out_valid(ov[2]), .out_last(ol[2]), .out_ready(out_ready),
      .msg_len(ml[2]), .msg_done(md[2]));

   function automatic int ww(input int d);
      return d == 2 ? 2 : 1;
   endfunction

   function automatic int ee(input int d);
      return d == 1 ? 1 : 0;
   endfunction

   // expected beats: chunk the message into 4W-byte groups, lane order per endianness, zero pad
   function automatic beat_q_t model(input bq_t b, input int w, input int e);
      beat_q_t r;
      beat_t bt;
      int nb;
      nb = 4 * w;
      for (int s = 0; s < b.size(); s += nb) begin
         bt = '0;
         for (int k = 0; k < nb; k++)
            if (s + k < b.size()) begin
               bt[32 * (k / 4) + 8 * (e != 0 ? 3 - k % 4 : k % 4) +: 8] = b[s + k];
               bt[64 + k] = 1'b1;
            end
         bt[72] = (s + nb >= b.size());
         r.push_back(bt);
      end
      return r;
   endfunction

   // one cycle: sample handshakes 1ns after the negedge, then advance to the next negedge
   task automatic tick();
      #1;
      for (int d = 0; d < 3; d++) begin
         if (ov[d] && out_ready)
            cap[d].push_back(obeat[d]);
         if (md[d])
            dn[d]++;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear();
      for (int d = 0; d < 3; d++) begin
         cap[d].delete();
         exp_q[d].delete();
         dn[d] = 0;
      end
   endtask

   // bytes are offered only when every DUT is ready, so all three see identical transfers
   task automatic send(input bq_t b, input int pct, input bit with_last);
      beat_q_t m;
      for (int d = 0; d < 3; d++) begin
         m = model(b, ww(d), ee(d));
         foreach (m[i]) exp_q[d].push_back(m[i]);
      end
      for (int i = 0; i < b.size(); i++) begin
         int n;
         logic took;
         n = 0;
         took = 1'b0;
         in_byte = b[i];
         in_last = with_last && (i == b.size() - 1);
         while (!took && n < 200) begin
            in_valid = &ir;
            out_ready = ($urandom_range(99) < pct);
            took = in_valid;
            tick();
            n++;
         end
         cmp_n++;
         if (!took) begin
            err_n++;
            $display("FAIL send_timeout byte %0d got not_accepted want accepted", i);
         end
      end
      in_valid = 1'b0;
      in_last = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      while (n < 100 && !(cap[0].size() >= exp_q[0].size() && cap[1].size() >= exp_q[1].size()
                          && cap[2].size() >= exp_q[2].size())) begin
         tick();
         n++;
      end
      repeat (3) tick();
      cmp_n++;
      if (n >= 100) begin
         err_n++;
         $display("FAIL drain_timeout got %0d/%0d/%0d beats want %0d/%0d/%0d", cap[0].size(), cap[1].size(),
                  cap[2].size(), exp_q[0].size(), exp_q[1].size(), exp_q[2].size());
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      for (int pass = 0; pass < 2; pass++) begin
         for (int d = 0; d < 3; d++) begin
            cmp_n++;
            if ({obeat[d], ov[d], md[d], ml[d]} !== '0 || ir[d] !== 1'b1) begin
               err_n++;
               $display("FAIL reset dut%0d got beat=%h v=%b done=%b len=%0d rdy=%b want zeros rdy=1", d, obeat[d],
                        ov[d], md[d], ml[d], ir[d]);
            end
         end
         rst_n = 1'b1;
         tick();
      end
   endtask

   task automatic test_basic();
      beat_t want[3];
      bq_t b;
      b = '{8'h01, 8'h02, 8'h03, 8'h04};
      want[0] = {1'b1, 8'h0F, 64'h0403_0201};
      want[1] = {1'b1, 8'h0F, 64'h0102_0304};
      want[2] = {1'b1, 8'h0F, 64'h0403_0201};
      clear();
      send(b, 100, 1'b1);
      drain();
      for (int d = 0; d < 3; d++) begin
         cmp_n++;
         if (cap[d].size() != 1 || cap[d][0] !== want[d]) begin
            err_n++;
            $display("FAIL basic_beat dut%0d got n=%0d %h want n=1 %h", d, cap[d].size(), cap[d][0], want[d]);
         end
         cmp_n++;
         if (ml[d] !== 32'd4 || dn[d] != 1) begin
            err_n++;
            $display("FAIL basic_len dut%0d got len=%0d done=%0d want len=4 done=1", d, ml[d], dn[d]);
         end
      end
   endtask

   task automatic test_partial();
      beat_t want[2];
      bq_t b;
      b = '{8'hAA, 8'hAB, 8'hAC, 8'hAD, 8'hAE, 8'hAF};
      want[0] = {1'b0, 8'h0F, 64'hADAC_ABAA};
      want[1] = {1'b1, 8'h03, 64'h0000_AFAE};
      clear();
      send(b, 100, 1'b1);
      drain();
      for (int i = 0; i < 2; i++) begin
         cmp_n++;
         if (cap[0].size() != 2 || cap[0][i] !== want[i]) begin
            err_n++;
            $display("FAIL partial_le beat%0d got %h want %h", i, cap[0][i], want[i]);
         end
      end
      for (int d = 1; d < 3; d++) begin
         cmp_n++;
         if (cap[d] != exp_q[d] || ml[d] !== 32'd6) begin
            err_n++;
            $display("FAIL partial dut%0d got n=%0d len=%0d want n=%0d len=6", d, cap[d].size(), ml[d],
                     exp_q[d].size());
         end
      end
   endtask

   task automatic test_wide();
      beat_t want[2];
      bq_t b;
      b = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      want[0] = {1'b0, 8'hFF, 64'h0706_0504_0302_0100};
      want[1] = {1'b1, 8'h01, 64'h08};
      clear();
      send(b, 100, 1'b1);
      drain();
      for (int i = 0; i < 2; i++) begin
         cmp_n++;
         if (cap[2].size() != 2 || cap[2][i] !== want[i]) begin
            err_n++;
            $display("FAIL wide beat%0d got %h want %h", i, cap[2][i], want[i]);
         end
      end
      cmp_n++;
      if (ml[2] !== 32'd9 || dn[2] != 1) begin
         err_n++;
         $display("FAIL wide_len got len=%0d done=%0d want len=9 done=1", ml[2], dn[2]);
      end
   endtask

   task automatic test_backpressure();
      bq_t b;
      beat_t first;
      b = {};
      for (int i = 0; i < 8; i++) b.push_back(8'($urandom));
      clear();
      send(b, 0, 1'b1);
      first = exp_q[0][0];
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         cmp_n++;
         if (ir[0] !== 1'b0 || ir[1] !== 1'b0) begin
            err_n++;
            $display("FAIL bp_ready cycle%0d got %b%b want 00", c, ir[0], ir[1]);
         end
         cmp_n++;
         if (ov[0] !== 1'b1 || obeat[0] !== first) begin
            err_n++;
            $display("FAIL bp_hold cycle%0d got v=%b %h want v=1 %h", c, ov[0], obeat[0], first);
         end
         tick();
      end
      drain();
      for (int d = 0; d < 3; d++) begin
         cmp_n++;
         if (cap[d] != exp_q[d] || ml[d] !== 32'd8 || dn[d] != 1) begin
            err_n++;
            $display("FAIL bp_order dut%0d got n=%0d len=%0d done=%0d want n=%0d len=8 done=1", d, cap[d].size(),
                     ml[d], dn[d], exp_q[d].size());
         end
      end
   endtask

   task automatic test_random();
      bq_t b;
      int len;
      clear();
      len = 0;
      for (int m = 0; m < 6; m++) begin
         len = $urandom_range(17, 1);
         b = {};
         for (int i = 0; i < len; i++) b.push_back(8'($urandom));
         send(b, $urandom_range(100, 30), 1'b1);
      end
      drain();
      for (int d = 0; d < 3; d++) begin
         cmp_n++;
         if (cap[d].size() != exp_q[d].size()) begin
            err_n++;
            $display("FAIL rand_count dut%0d got %0d want %0d", d, cap[d].size(), exp_q[d].size());
         end
         for (int i = 0; i < exp_q[d].size() && i < cap[d].size(); i++) begin
            cmp_n++;
            if (cap[d][i] !== exp_q[d][i]) begin
               err_n++;
               $display("FAIL rand_beat dut%0d #%0d got %h want %h", d, i, cap[d][i], exp_q[d][i]);
            end
         end
         cmp_n++;
         if (ml[d] !== 32'(len) || dn[d] != 6) begin
            err_n++;
            $display("FAIL rand_len dut%0d got len=%0d done=%0d want len=%0d done=6", d, ml[d], dn[d], len);
         end
      end
   endtask

   task automatic test_reset_mid();
      bq_t b;
      beat_t want;
      b = '{8'h55, 8'h66, 8'h77};
      clear();
      send(b, 100, 1'b0);
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         cmp_n++;
         if ({obeat[d], ov[d], md[d], ml[d]} !== '0 || ir[d] !== 1'b1) begin
            err_n++;
            $display("FAIL mid_reset dut%0d got beat=%h v=%b len=%0d rdy=%b want zeros rdy=1", d, obeat[d], ov[d],
                     ml[d], ir[d]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      clear();
      b = '{8'h10, 8'h11, 8'h12, 8'h13};
      want = {1'b1, 8'h0F, 64'h1312_1110};
      send(b, 100, 1'b1);
      drain();
      cmp_n++;
      if (cap[0].size() != 1 || cap[0][0] !== want) begin
         err_n++;
         $display("FAIL mid_restart got n=%0d %h want n=1 %h", cap[0].size(), cap[0][0], want);
      end
      for (int d = 0; d < 3; d++) begin
         cmp_n++;
         if (cap[d] != exp_q[d] || ml[d] !== 32'd4) begin
            err_n++;
            $display("FAIL mid_len dut%0d got n=%0d len=%0d want n=%0d len=4", d, cap[d].size(), ml[d],
                     exp_q[d].size());
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_partial();
      test_wide();
      test_backpressure();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got running want finished");
      $fatal(1, "watchdog expired");
   end
endmodule
